// File: rtl/rst_seq_mgr.sv
// Reset sequencer: qualifies a raw PLL lock and releases NUM_DOMAINS active-low resets, lowest index first.
// Latency: SYNC_STAGES sync + STABLE_CYC qualify + GAP_CYC per domain; reassertion one cycle after lock_s drop or sw_rst.
// Backpressure: none; free-running sequencer, all outputs registered.
module rst_seq_mgr #(
    parameter int NUM_DOMAINS = 3,
    parameter int SYNC_STAGES = 2,
    parameter int STABLE_CYC  = 1024,
    parameter int GAP_CYC     = 16,
    parameter int LOSS_CNT_W  = 8
) (
    input  logic                   clk,
    input  logic                   arst_n,
    input  logic                   pll_lock,
    input  logic                   sw_rst,
    input  logic                   cnt_clr,
    output logic [NUM_DOMAINS-1:0] srst_n,
    output logic                   all_ready,
    output logic [LOSS_CNT_W-1:0]  loss_cnt,
    output logic [1:0]             state
);

    localparam int SCW = $clog2(STABLE_CYC + 1);
    localparam int GCW = $clog2(GAP_CYC + 1);
    localparam logic [SCW-1:0] STABLE_LAST = SCW'(STABLE_CYC - 1);
    localparam logic [GCW-1:0] GAP_LAST    = GCW'(GAP_CYC - 1);
    localparam logic [NUM_DOMAINS-1:0] DOM0 = NUM_DOMAINS'(1);

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        STABLE    = 2'd1,
        RELEASE   = 2'd2,
        RUN       = 2'd3
    } state_t;

    state_t                 st;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   lock_s;
    logic [SCW-1:0]         stable_cnt;
    logic [GCW-1:0]         gap_cnt;
    logic                   loss_evt;

    assign lock_s = sync_q[SYNC_STAGES-1];
    assign state  = st;

    // Only a lock drop after release has started counts as a loss; drops during qualification are silent.
    assign loss_evt = ((st == RELEASE) || (st == RUN)) && !lock_s;

    // Metastability synchroniser for the asynchronous PLL lock.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pll_lock};
        end
    end

    // Sequencer FSM: qualify lock, release domains one by one as a thermometer, drop all together on loss/sw_rst.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            st         <= WAIT_LOCK;
            stable_cnt <= '0;
            gap_cnt    <= '0;
            srst_n     <= '0;
            all_ready  <= 1'b0;
        end else begin
            case (st)
                WAIT_LOCK: begin
                    if (lock_s) begin
                        st         <= STABLE;
                        stable_cnt <= '0;
                    end
                end
                STABLE: begin
                    if (!lock_s || sw_rst) begin
                        st <= WAIT_LOCK;
                    end else if (stable_cnt == STABLE_LAST) begin
                        st      <= RELEASE;
                        gap_cnt <= '0;
                        srst_n  <= DOM0;
                    end else begin
                        stable_cnt <= stable_cnt + SCW'(1);
                    end
                end
                RELEASE: begin
                    if (!lock_s || sw_rst) begin
                        st     <= WAIT_LOCK;
                        srst_n <= '0;
                    end else if (srst_n[NUM_DOMAINS-1]) begin
                        st        <= RUN;
                        all_ready <= 1'b1;
                    end else if (gap_cnt == GAP_LAST) begin
                        // Shifting a 1 in keeps every released domain above an already-released one.
                        gap_cnt <= '0;
                        srst_n  <= (srst_n << 1) | DOM0;
                    end else begin
                        gap_cnt <= gap_cnt + GCW'(1);
                    end
                end
                RUN: begin
                    if (!lock_s || sw_rst) begin
                        st        <= WAIT_LOCK;
                        srst_n    <= '0;
                        all_ready <= 1'b0;
                    end
                end
                default: begin
                    st <= WAIT_LOCK;
                end
            endcase
        end
    end

    // Saturating lock-loss counter; a clear coinciding with a loss leaves that loss counted.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            loss_cnt <= '0;
        end else if (cnt_clr) begin
            loss_cnt <= loss_evt ? LOSS_CNT_W'(1) : '0;
        end else if (loss_evt && !(&loss_cnt)) begin
            loss_cnt <= loss_cnt + LOSS_CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_rst_seq_mgr.sv
// Bench for rst_seq_mgr: directed test-plan scenarios followed by random lock/sw_rst/cnt_clr traffic.
// A timing model derived from elapsed-cycle arithmetic predicts every cycle's outputs into a scoreboard queue.
// A negedge monitor pops and compares; a second instance with a 2-bit loss counter shares all inputs.
module tb_rst_seq_mgr;

    localparam int N    = 3;
    localparam int SYNC = 2;
    localparam int SC   = 1024;
    localparam int G    = 16;

    typedef struct packed {
        logic [N-1:0] srst;
        logic         ar;
        logic [1:0]   st;
        logic [7:0]   l8;
        logic [1:0]   l2;
    } exp_t;

    logic         clk = 1'b0;
    logic         arst_n = 1'b0;
    logic         pll_lock = 1'b0;
    logic         sw_rst = 1'b0;
    logic         cnt_clr = 1'b0;
    logic [N-1:0] srst_n, srst_n_b;
    logic         all_ready, all_ready_b;
    logic [7:0]   loss_cnt;
    logic [1:0]   loss_cnt_b;
    logic [1:0]   state, state_b;

    rst_seq_mgr #(.NUM_DOMAINS(N), .SYNC_STAGES(SYNC), .STABLE_CYC(SC), .GAP_CYC(G), .LOSS_CNT_W(8)) dut (
        .clk(clk), .arst_n(arst_n), .pll_lock(pll_lock), .sw_rst(sw_rst), .cnt_clr(cnt_clr),
        .srst_n(srst_n), .all_ready(all_ready), .loss_cnt(loss_cnt), .state(state)
    );

    rst_seq_mgr #(.NUM_DOMAINS(N), .SYNC_STAGES(SYNC), .STABLE_CYC(SC), .GAP_CYC(G), .LOSS_CNT_W(2)) dut_w2 (
        .clk(clk), .arst_n(arst_n), .pll_lock(pll_lock), .sw_rst(sw_rst), .cnt_clr(cnt_clr),
        .srst_n(srst_n_b), .all_ready(all_ready_b), .loss_cnt(loss_cnt_b), .state(state_b)
    );

    always #5 clk = ~clk;

    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    exp_t sb[$];

    // reference model: qualification timer and loss counts
    bit   qual = 1'b0;
    int   age = 0;
    int   loss8 = 0;
    int   loss2 = 0;
    bit   lpipe[$];

    // edge recorders (edge index at which the new value is first sampled)
    int         rise_at[N];
    int         ar_at = -1;
    int         fall_at = -1;
    logic [N-1:0] prev_srst = '0;
    logic         prev_ar = 1'b0;

    function automatic void chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d", nm, act, act, exp, exp, cyc);
        end
    endfunction

    function automatic exp_t expect_out();
        exp_t e;
        int   r;
        int   nrel;
        e = '0;
        if (qual && age >= SC) begin
            r    = age - SC;
            nrel = r / G + 1;
            if (nrel > N) nrel = N;
            e.srst = N'((1 << nrel) - 1);
            e.ar   = (r >= (N - 1) * G + 1);
            e.st   = e.ar ? 2'd3 : 2'd2;
        end else if (qual) begin
            e.st = 2'd1;
        end
        e.l8 = 8'(loss8);
        e.l2 = 2'(loss2);
        return e;
    endfunction

    // Model: advances once per clock edge using the input values present before that edge.
    initial begin
        forever begin
            bit ls;
            bit evt;
            @(posedge clk);
            cyc++;
            if (!arst_n) begin
                qual  = 1'b0;
                age   = 0;
                loss8 = 0;
                loss2 = 0;
                lpipe = {};
                for (int i = 0; i < SYNC; i++) lpipe.push_back(1'b0);
            end else begin
                ls = lpipe[SYNC-1];
                void'(lpipe.pop_back());
                lpipe.push_front(pll_lock);
                evt = 1'b0;
                if (!qual) begin
                    if (ls) begin
                        qual = 1'b1;
                        age  = 0;
                    end
                end else if (age < SC) begin
                    if (!ls || sw_rst) qual = 1'b0;
                    else age++;
                end else begin
                    if (!ls) begin
                        qual = 1'b0;
                        evt  = 1'b1;
                    end else if (sw_rst) begin
                        qual = 1'b0;
                    end else begin
                        age++;
                    end
                end
                if (cnt_clr) begin
                    loss8 = int'(evt);
                    loss2 = int'(evt);
                end else if (evt) begin
                    if (loss8 < 255) loss8++;
                    if (loss2 < 3) loss2++;
                end
            end
            sb.push_back(expect_out());
        end
    end

    // Monitor: compares every presented output word against the scoreboard and records edges.
    initial begin
        forever begin
            exp_t e;
            @(negedge clk);
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL sb_empty: no expected entry at cycle %0d", cyc);
            end else begin
                e = sb.pop_front();
                chk("out_w8", int'({srst_n, all_ready, state, loss_cnt, loss_cnt_b}), int'(e));
                chk("out_w2", int'({srst_n_b, all_ready_b, state_b}), int'({e.srst, e.ar, e.st}));
            end
            for (int k = 0; k < N; k++)
                if (srst_n[k] && !prev_srst[k]) rise_at[k] = cyc + 1;
            if (all_ready && !prev_ar) ar_at = cyc + 1;
            if ((prev_srst & ~srst_n) != '0) begin
                fall_at = cyc + 1;
                chk("group_assert", int'(srst_n), 0);
            end
            prev_srst = srst_n;
            prev_ar   = all_ready;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic reset_rec();
        for (int k = 0; k < N; k++) rise_at[k] = -1;
        ar_at   = -1;
        fall_at = -1;
    endtask

    task automatic wait_ar(input logic v, input int budget, input string nm);
        int i = 0;
        while (all_ready !== v && i < budget) begin
            tick(1);
            i++;
        end
        chk(nm, int'(all_ready === v), 1);
    endtask

    task automatic wait_state(input logic [1:0] s, input int budget, input string nm);
        int i = 0;
        while (state !== s && i < budget) begin
            tick(1);
            i++;
        end
        chk(nm, int'(state === s), 1);
    endtask

    task automatic wait_srst(input logic [N-1:0] v, input int budget, input string nm);
        int i = 0;
        while (srst_n !== v && i < budget) begin
            tick(1);
            i++;
        end
        chk(nm, int'(srst_n === v), 1);
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation did not finish (total=%0d bad=%0d)", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        int lock_edge;
        int drop_edge;
        bit seen;
        reset_rec();

        // reset state
        tick(2);
        chk("reset_srst", int'(srst_n), 0);
        chk("reset_ready", int'(all_ready), 0);
        chk("reset_state", int'(state), 0);
        chk("reset_loss", int'(loss_cnt), 0);
        #2 arst_n = 1'b1;
        tick(2);

        // lock glitch during qualification
        pll_lock = 1'b1;
        wait_state(2'd1, 20, "enter_stable");
        tick(500);
        pll_lock = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick(1);
            if (state == 2'd0) seen = 1'b1;
        end
        chk("glitch_to_wait", int'(seen), 1);
        chk("glitch_loss", int'(loss_cnt), 0);

        // nominal release, measured from the restored lock
        reset_rec();
        pll_lock  = 1'b1;
        lock_edge = cyc + 1;
        wait_ar(1'b1, SC + 200, "nominal_ready");
        tick(1);
        chk("srst0_delay", rise_at[0] - lock_edge, SC + 1 + SYNC);
        chk("srst1_gap", rise_at[1] - rise_at[0], G);
        chk("srst2_gap", rise_at[2] - rise_at[0], 2 * G);
        chk("ready_delay", ar_at - rise_at[0], (N - 1) * G + 1);
        chk("nominal_loss", int'(loss_cnt), 0);

        // lock loss in RUN
        tick(10);
        pll_lock  = 1'b0;
        drop_edge = cyc + 1;
        wait_srst('0, 10, "loss_assert");
        tick(1);
        chk("loss_assert_delay", fall_at - drop_edge, SYNC + 1);
        chk("loss_cnt_one", int'(loss_cnt), 1);
        chk("loss_ready_low", int'(all_ready), 0);

        // replay, then software reset with only domain 0 released
        pll_lock = 1'b1;
        wait_srst(N'(1), SC + 100, "replay_srst0");
        sw_rst = 1'b1;
        tick(1);
        sw_rst = 1'b0;
        chk("sw_srst", int'(srst_n), 0);
        chk("sw_state", int'(state), 0);
        chk("sw_loss", int'(loss_cnt), 1);

        // async reset in the middle of the re-run release
        wait_state(2'd2, SC + 100, "rerun_release");
        #2 arst_n = 1'b0;
        #1;
        chk("arst_srst", int'(srst_n), 0);
        chk("arst_ready", int'(all_ready), 0);
        chk("arst_state", int'(state), 0);
        chk("arst_loss", int'(loss_cnt), 0);
        tick(2);
        #2 arst_n = 1'b1;
        wait_state(2'd1, 20, "restart_stable");
        wait_ar(1'b1, SC + 200, "restart_ready");

        // saturation: five losses
        for (int i = 0; i < 5; i++) begin
            pll_lock = 1'b1;
            wait_ar(1'b1, SC + 200, "sat_ready");
            pll_lock = 1'b0;
            wait_state(2'd0, 10, "sat_drop");
        end
        chk("sat_w2", int'(loss_cnt_b), 3);
        chk("sat_w8", int'(loss_cnt), 5);

        // clear coinciding with a loss
        pll_lock = 1'b1;
        wait_ar(1'b1, SC + 200, "clr_ready");
        pll_lock = 1'b0;
        tick(2);
        cnt_clr = 1'b1;
        tick(1);
        cnt_clr = 1'b0;
        chk("clr_loss_w2", int'(loss_cnt_b), 1);
        chk("clr_loss_w8", int'(loss_cnt), 1);
        tick(3);
        cnt_clr = 1'b1;
        tick(1);
        cnt_clr = 1'b0;
        chk("clr_only", int'(loss_cnt), 0);

        // random traffic
        for (int it = 0; it < 25; it++) begin
            int dwell;
            int sw_at;
            int clr_at;
            dwell  = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 8)) : int'($urandom_range(200, 1300));
            sw_at  = int'($urandom_range(0, 3 * dwell));
            clr_at = int'($urandom_range(0, 3 * dwell));
            pll_lock = ($urandom_range(0, 3) != 0);
            for (int c = 0; c < dwell; c++) begin
                sw_rst  = (c == sw_at);
                cnt_clr = (c == clr_at);
                tick(1);
            end
            sw_rst  = 1'b0;
            cnt_clr = 1'b0;
        end

        tick(3);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rst_seq_mgr.md
# rst_seq_mgr

Parametrised reset sequencer that qualifies a raw PLL lock indication and releases `NUM_DOMAINS` synchronous active-low resets in a fixed order with programmable spacing. It sits directly behind the technology PLL/clock-divider wrapper and drives the reset inputs of the pixel pipeline, TMDS serialisers and game logic. It also re-runs the sequence on a software request and counts lock-loss events for debug.

## Interface
- `NUM_DOMAINS`, default 3: number of sequenced reset outputs; must be ≥1.
- `SYNC_STAGES`, default 2: depth of the synchroniser on `pll_lock`; must be ≥2.
- `STABLE_CYC`, default 1024: number of consecutive synchronised-high cycles of lock required before release; must be ≥1.
- `GAP_CYC`, default 16: cycles between successive domain releases; must be ≥1.
- `LOSS_CNT_W`, default 8: width of the lock-loss counter.
- `clk`  in  1  sequencer clock; this is the pixel clock from the PLL wrapper.
- `arst_n`  in  1  asynchronous, active-low reset.
- `pll_lock`  in  1  raw PLL lock; asynchronous to `clk`.
- `sw_rst`  in  1  synchronous single-cycle request to re-run the sequence.
- `cnt_clr`  in  1  synchronous clear of `loss_cnt`.
- `srst_n`  out  NUM_DOMAINS  per-domain synchronous reset; bit 0 is released first.
- `all_ready`  out  1  high when every domain is released.
- `loss_cnt`  out  LOSS_CNT_W  saturating count of lock losses.
- `state`  out  2  FSM state for debug: 0=WAIT_LOCK, 1=STABLE, 2=RELEASE, 3=RUN.

## Operation
- Synchroniser: `pll_lock` passes through `SYNC_STAGES` flops to produce `lock_s`.
- WAIT_LOCK: all `srst_n` are 0. When `lock_s`=1, clear the stable counter and go to STABLE.
- STABLE: the stable counter increments every cycle.
  - If `lock_s`=0, go to WAIT_LOCK. `loss_cnt` is not incremented.
  - When the counter equals `STABLE_CYC-1`, go to RELEASE. Set domain index to 0 and gap counter to 0.
- RELEASE: `srst_n[0]` goes to 1 on the entry edge.
  - The gap counter counts 0..`GAP_CYC-1`. On wrap, the index increments and `srst_n[index]` goes to 1.
  - Once `srst_n[NUM_DOMAINS-1]` is 1, the next edge enters RUN.
  - With `NUM_DOMAINS`=1, RUN is entered on the edge after `srst_n[0]` rises.
- RUN: `all_ready`=1. All `srst_n` stay 1.
- Lock loss (`lock_s`=0 while in RELEASE or RUN):
  - On the next edge, all `srst_n` go to 0 together and `all_ready` goes to 0.
  - `loss_cnt` increments and state becomes WAIT_LOCK.
- `sw_rst`=1 in STABLE, RELEASE or RUN: on the next edge, all `srst_n` go to 0 and state becomes WAIT_LOCK. `loss_cnt` is unchanged. `sw_rst` is ignored in WAIT_LOCK.
- Simultaneous `sw_rst` and lock loss: treated as a lock loss, so the count increments.
- `loss_cnt`:
  - Saturates at all-ones.
  - `cnt_clr` sets it to 0 on the next edge.
  - `cnt_clr` together with a loss event yields 1.
- Resets assert as a group but deassert in order. No domain is ever released while a lower-indexed domain is held.

## Timing
- All outputs are registered; there is no combinational input-to-output path.
- `arst_n`=0 asynchronously forces:
  - `srst_n`=0, `all_ready`=0, `loss_cnt`=0, `state`=0;
  - synchroniser flops and all counters to 0.
- Lock rising: let T be the first edge at which `lock_s`=1. Then `state`=STABLE from T+1 and `srst_n[0]` rises at T+STABLE_CYC+1.
- Domain spacing: `srst_n[k]` rises `k*GAP_CYC` cycles after `srst_n[0]`. `all_ready` rises one cycle after `srst_n[NUM_DOMAINS-1]`.
- `pll_lock` edge to `lock_s`: `SYNC_STAGES` cycles, ±1 for metastability resolution.
- Lock drop to reset assertion: `lock_s` falls at edge L, and all `srst_n` are 0 at L+1.
- `sw_rst` sampled at edge S: all `srst_n` are 0 at S+1. Re-release then requires the full STABLE count again.
- `arst_n` deassertion mid-sequence restarts at WAIT_LOCK.

## Test plan
- Nominal release (defaults, `pll_lock` held high after reset):
  - `srst_n[0]` rises 1024+1+2 cycles after the first sampled edge of `pll_lock`;
  - `srst_n[1]` rises 16 cycles later and `srst_n[2]` 32 cycles later;
  - `all_ready` rises 33 cycles after `srst_n[0]`;
  - `loss_cnt`=0.
- Lock glitch during STABLE: drop `pll_lock` for 5 cycles at count 500, then restore.
  - State returns to WAIT_LOCK and `loss_cnt`=0.
  - Release occurs a full 1024 cycles after `lock_s` recovers.
- Lock loss in RUN: drop `pll_lock`.
  - All three `srst_n` go to 0 on the same edge, `SYNC_STAGES`+1 cycles later.
  - `loss_cnt`=1 and `all_ready`=0.
  - Restoring `pll_lock` replays the sequence.
- Software reset in RELEASE: pulse `sw_rst` after only `srst_n[0]` has been released.
  - All `srst_n` are 0 next cycle and `loss_cnt` is unchanged.
  - The full sequence re-runs.
- Counter saturation and clear (`LOSS_CNT_W`=2):
  - 5 losses give `loss_cnt`=3.
  - `cnt_clr` together with a loss gives `loss_cnt`=1.
- Mid-sequence async reset: assert `arst_n` low during RELEASE.
  - All outputs go to 0 immediately, without waiting for a clock edge.
  - After deassertion the sequence restarts from WAIT_LOCK.
